timer_min_seg: RTL and testbench

Three-digit M:SS countdown timer built as a cascade of BCD down-counters: seconds units (mod 10), seconds tens (mod 6) and minutes units (mod 10). It consumes the 1-per-second enable tick from the clock divider. It drives the display decoders and the control FSM that switches the load off at 0:00. Each digit's borrow propagates to the next digit within the same clock cycle, so the whole display steps once per tick.

---
 rtl/timer_min_seg.sv | 100 ++++++++++
 tb/tb_timer_min_seg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/timer_min_seg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_min_seg
//  Description : M:SS countdown timer built from three cascaded BCD
//                down-counters (seconds units mod 10, seconds tens mod 6,
//                minutes units mod 10). Stops at 0:00 and pulses done once
//                when the count arrives there by decrementing.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_min_seg (
   input  logic       clk,
   input  logic       clearn,
   input  logic       loadn,
   input  logic       en,
   input  logic [3:0] data_min,
   input  logic [3:0] data_tens,
   input  logic [3:0] data_units,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       zero,
   output logic       done
);

   localparam logic [3:0] c_max_units = 4'd9;
   localparam logic [3:0] c_max_tens  = 4'd5;
   localparam logic [3:0] c_max_min   = 4'd9;

   logic [3:0] r_min;
   logic [3:0] r_tens;
   logic [3:0] r_units;
   logic       r_done;

   logic [3:0] w_load_min;
   logic [3:0] w_load_tens;
   logic [3:0] w_load_units;
   logic [3:0] w_next_min;
   logic [3:0] w_next_tens;
   logic [3:0] w_next_units;
   logic       w_zero;
   logic       w_borrow_units;
   logic       w_borrow_tens;
   logic       w_at_one;

   // Clamp load data so the digit registers can only ever hold legal BCD.
   always_comb begin
      w_load_min   = (data_min   > c_max_min)   ? c_max_min   : data_min;
      w_load_tens  = (data_tens  > c_max_tens)  ? c_max_tens  : data_tens;
      w_load_units = (data_units > c_max_units) ? c_max_units : data_units;
   end

   // Decrement cascade: borrows ripple through all digits within one cycle.
   always_comb begin
      w_zero         = (r_min == 4'd0) && (r_tens == 4'd0) && (r_units == 4'd0);
      w_borrow_units = (r_units == 4'd0);
      w_borrow_tens  = w_borrow_units && (r_tens == 4'd0);
      w_at_one       = (r_min == 4'd0) && (r_tens == 4'd0) && (r_units == 4'd1);

      w_next_units = w_borrow_units ? c_max_units : (r_units - 4'd1);
      w_next_tens  = r_tens;
      w_next_min   = r_min;
      if (w_borrow_units) begin
         w_next_tens = (r_tens == 4'd0) ? c_max_tens : (r_tens - 4'd1);
      end
      if (w_borrow_tens) begin
         // Only reached when min is non-zero, since 0:00 never decrements.
         w_next_min = r_min - 4'd1;
      end
   end

   // Digit and done registers: clear, then load, then count, else hold.
   always_ff @(posedge clk) begin
      if (!clearn) begin
         r_min   <= 4'd0;
         r_tens  <= 4'd0;
         r_units <= 4'd0;
         r_done  <= 1'b0;
      end else if (!loadn) begin
         r_min   <= w_load_min;
         r_tens  <= w_load_tens;
         r_units <= w_load_units;
         r_done  <= 1'b0;
      end else if (en && !w_zero) begin
         r_min   <= w_next_min;
         r_tens  <= w_next_tens;
         r_units <= w_next_units;
         r_done  <= w_at_one;
      end else begin
         r_done  <= 1'b0;
      end
   end

   assign min_units = r_min;
   assign sec_tens  = r_tens;
   assign sec_units = r_units;
   assign zero      = w_zero;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer_min_seg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_min_seg
//  Description : Directed self-checking bench for the M:SS countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_min_seg;

   logic       clk;
   logic       clearn;
   logic       loadn;
   logic       en;
   logic [3:0] data_min;
   logic [3:0] data_tens;
   logic [3:0] data_units;
   logic [3:0] min_units;
   logic [3:0] sec_tens;
   logic [3:0] sec_units;
   logic       zero;
   logic       done;

   int r_tests;
   int r_fails;
   int r_done_count;

   timer_min_seg u_dut (
      .clk        (clk),
      .clearn     (clearn),
      .loadn      (loadn),
      .en         (en),
      .data_min   (data_min),
      .data_tens  (data_tens),
      .data_units (data_units),
      .min_units  (min_units),
      .sec_tens   (sec_tens),
      .sec_units  (sec_units),
      .zero       (zero),
      .done       (done)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in the bench.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      r_tests++;
      if (act !== exp) begin
         r_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One rising edge, then settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
      if (done === 1'b1) r_done_count++;
   endtask

   function automatic logic [11:0] disp();
      return {min_units, sec_tens, sec_units};
   endfunction

   task automatic load(input logic [3:0] m, input logic [3:0] t, input logic [3:0] u);
      loadn = 1'b0; en = 1'b0;
      data_min = m; data_tens = t; data_units = u;
      step();
      loadn = 1'b1;
   endtask

   initial begin
      r_tests = 0;
      r_fails = 0;
      r_done_count = 0;

      // Reset with conflicting load/en/data present
      clearn = 1'b0; loadn = 1'b0; en = 1'b1;
      data_min = 4'd9; data_tens = 4'd5; data_units = 4'd9;
      step();
      check("reset_digits", disp(), 12'h000);
      check("reset_zero", zero, 1'b1);
      check("reset_done", done, 1'b0);

      // en pulses at 0:00 do nothing
      clearn = 1'b1; loadn = 1'b1; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_digits", disp(), 12'h000);
         check("idle_done", done, 1'b0);
      end

      // Load 1:00 and cascade
      load(4'd1, 4'd0, 4'd0);
      check("load_100", disp(), 12'h100);
      check("load_100_zero", zero, 1'b0);
      check("load_100_done", done, 1'b0);
      step();
      check("hold_en0", disp(), 12'h100);
      en = 1'b1;
      step();
      check("cascade_059", disp(), 12'h059);
      for (int i = 0; i < 58; i++) step();
      check("reach_001", disp(), 12'h001);
      check("reach_001_zero", zero, 1'b0);
      check("reach_001_done", done, 1'b0);
      r_done_count = 0;
      step();
      check("reach_000", disp(), 12'h000);
      check("reach_000_zero", zero, 1'b1);
      check("reach_000_done", done, 1'b1);
      step();
      check("terminal_hold", disp(), 12'h000);
      check("done_one_cycle", done, 1'b0);
      step();
      check("done_pulse_count", r_done_count, 1);
      en = 1'b0;

      // Full run from 9:59, compared against a seconds-remaining model
      load(4'd9, 4'd5, 4'd9);
      check("load_959", disp(), 12'h959);
      en = 1'b1;
      r_done_count = 0;
      for (int i = 1; i <= 599; i++) begin
         int rem;
         logic [11:0] exp_d;
         step();
         rem   = 599 - i;
         exp_d = {4'(rem / 60), 4'((rem % 60) / 10), 4'(rem % 10)};
         check("full_run_digits", disp(), exp_d);
         check("full_run_done", done, (rem == 0));
      end
      check("full_run_zero", zero, 1'b1);
      check("full_run_pulses", r_done_count, 1);
      en = 1'b0;

      // Clamping of out-of-range load data
      load(4'd12, 4'd7, 4'd15);
      check("clamp_959", disp(), 12'h959);
      load(4'd0, 4'd0, 4'd0);
      check("load_000", disp(), 12'h000);
      check("load_000_zero", zero, 1'b1);
      check("load_000_done", done, 1'b0);
      load(4'd3, 4'd9, 4'd4);
      check("clamp_tens", disp(), 12'h354);

      // Load beats en
      load(4'd2, 4'd3, 4'd0);
      check("load_230", disp(), 12'h230);
      loadn = 1'b0; en = 1'b1;
      data_min = 4'd0; data_tens = 4'd0; data_units = 4'd5;
      step();
      check("load_over_en", disp(), 12'h005);
      check("load_over_en_done", done, 1'b0);

      // Clear beats load
      clearn = 1'b0; loadn = 1'b0; en = 1'b0;
      data_min = 4'd9; data_tens = 4'd5; data_units = 4'd9;
      step();
      check("clear_over_load", disp(), 12'h000);
      check("clear_over_load_done", done, 1'b0);
      clearn = 1'b1; loadn = 1'b1;

      // Clear mid-count suppresses the done pulse
      load(4'd0, 4'd0, 4'd3);
      r_done_count = 0;
      en = 1'b1;
      step();
      check("mid_002", disp(), 12'h002);
      clearn = 1'b0;
      step();
      check("mid_clear", disp(), 12'h000);
      check("mid_clear_done", done, 1'b0);
      clearn = 1'b1;
      step();
      step();
      check("mid_after", disp(), 12'h000);
      check("mid_no_pulse", r_done_count, 0);

      // Clear while done is high drops it
      load(4'd0, 4'd0, 4'd1);
      en = 1'b1;
      step();
      check("done_before_clear", done, 1'b1);
      en = 1'b0; clearn = 1'b0;
      step();
      check("done_cleared", done, 1'b0);
      clearn = 1'b1;

      $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
      $finish;
   end

endmodule
`default_nettype wire
